uart_rx_fifo: RTL

Parametrised UART receiver with an integrated receive FIFO. It is the next generation of the single-byte receiver + buffer pair in the hangman link. It deserialises the radio-side serial stream and applies optional parity and stop-bit checks. Valid characters are queued so that several guesses can arrive while the game FSM is busy. The game FSM pops characters with a ready/valid handshake.

---
 rtl/uart_rx_fifo.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (optional parity, stop check) feeding a first-word fall-through receive FIFO.
// Optional build macro HANGMAN_LETTER_FILTER_EN: fold a-z to A-Z, drop non-letters, flag err_char.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_serial,
  input  logic                          rec_ready,
  input  logic                          game_rdy,
  input  logic                          err_clr,
  output logic [DATA_BITS-1:0]          guess,
  output logic                          guess_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_LED,
  output logic                          err_frame,
  output logic                          err_parity,
`ifdef HANGMAN_LETTER_FILTER_EN
  output logic                          err_char,
`endif
  output logic                          err_overflow
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_err_q, par_err_d;
  logic                 rx_meta, rx_s, armed_q;
  logic                 bit_tick, push, accept, frame_set, parity_set;
  logic [DATA_BITS-1:0] push_data;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic                 full, do_push, do_pop, overflow_set;
  logic                 err_frame_d, err_parity_d, err_overflow_d;

  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
    end
  end

  assign bit_tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

`ifdef HANGMAN_LETTER_FILTER_EN
  localparam bit FILTER_ON = (DATA_BITS == 8);
  logic [7:0] raw8, fold8;
  logic       char_set, err_char_d;
  always_comb begin
    raw8  = 8'(shreg_q);
    fold8 = (raw8 >= 8'h61 && raw8 <= 8'h7A) ? raw8 - 8'h20 : raw8;
    if (FILTER_ON) begin
      push_data = DATA_BITS'(fold8);
      accept    = (fold8 >= 8'h41 && fold8 <= 8'h5A);
    end else begin
      push_data = shreg_q;
      accept    = 1'b1;
    end
  end
`else
  assign push_data = shreg_q;
  assign accept    = 1'b1;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    par_err_d  = par_err_q;
    push       = 1'b0;
    frame_set  = 1'b0;
    parity_set = 1'b0;
`ifdef HANGMAN_LETTER_FILTER_EN
    char_set   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s && rec_ready && armed_q) begin
          state_d   = S_START;
          bit_d     = '0;
          par_err_d = 1'b0;
        end
      end
      S_START: if (cnt_q == CNT_W'(CLKS_PER_BIT / 2 - 1)) begin
        cnt_d   = '0;
        state_d = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: if (bit_tick) begin
        cnt_d   = '0;
        shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
        bit_d   = bit_q + 1'b1;
        if (bit_q == BIT_W'(DATA_BITS - 1))
          state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: if (bit_tick) begin
        cnt_d     = '0;
        par_err_d = (rx_s != ((^shreg_q) ^ (PARITY_MODE == 2)));
        state_d   = S_STOP;
      end
      S_STOP: if (bit_tick) begin
        cnt_d   = '0;
        state_d = S_IDLE;
        if (!rx_s)          frame_set  = 1'b1;
        else if (par_err_q) parity_set = 1'b1;
        else if (accept)    push       = 1'b1;
`ifdef HANGMAN_LETTER_FILTER_EN
        else                char_set   = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // armed_q keeps IDLE from re-triggering on a line still held low after a bad stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      par_err_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      par_err_q <= par_err_d;
      armed_q   <= (state_q == S_IDLE) && (armed_q || rx_s);
    end
  end

  assign guess_valid  = (fifo_count != '0);
  assign full         = (fifo_count == (PTR_W + 1)'(FIFO_DEPTH));
  assign do_pop       = game_rdy && guess_valid;
  assign do_push      = push && (!full || do_pop);
  assign overflow_set = push && full && !do_pop;
  assign guess        = guess_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: storage is not reset; the count and pointers define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_comb begin
    err_frame_d    = frame_set    | (err_frame    & ~err_clr);
    err_parity_d   = parity_set   | (err_parity   & ~err_clr);
    err_overflow_d = overflow_set | (err_overflow & ~err_clr);
`ifdef HANGMAN_LETTER_FILTER_EN
    err_char_d     = char_set     | (err_char     & ~err_clr);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_frame    <= 1'b0;
      err_parity   <= 1'b0;
      err_overflow <= 1'b0;
      err_LED      <= 1'b0;
`ifdef HANGMAN_LETTER_FILTER_EN
      err_char     <= 1'b0;
`endif
    end else begin
      err_frame    <= err_frame_d;
      err_parity   <= err_parity_d;
      err_overflow <= err_overflow_d;
`ifdef HANGMAN_LETTER_FILTER_EN
      err_char     <= err_char_d;
      err_LED      <= err_frame_d | err_parity_d | err_overflow_d | err_char_d;
`else
      err_LED      <= err_frame_d | err_parity_d | err_overflow_d;
`endif
    end
  end

endmodule
